// File: rtl/bus_debug_bridge.sv
// bus_debug_bridge: UART byte-command to 32-bit system bus bridge (W/R commands, K/data/?/EE responses).
module bus_debug_bridge #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_en,
  output logic        bus_rdwr,
  output logic [3:0]  bus_mask,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rd_valid,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, WAIT_RD, RESP} state_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, last_q, last_d;
  logic is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, resp_q, resp_d;
  logic [3:0] mask_q, mask_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic rx_fire, tx_fire;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
      mask_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
    end
  end
  // Response bytes are shifted out of resp_q MSB first; last_q is the index of the final byte.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    resp_d  = resp_q;
    last_d  = last_q;
    tmo_d   = '0;
    case (state_q)
      IDLE: if (rx_fire) begin
        is_wr_d = rx_data == 8'h57;
        state_d = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : RESP;
        resp_d  = {8'h3F, 24'h0};
        last_d  = 2'd0;
      end
      ADDR: if (rx_fire) begin
        addr_d = {addr_q[23:0], rx_data};
        if (cnt_q == 2'd3) state_d = is_wr_q ? DATA : BUS_RD;
      end
      DATA: if (rx_fire) begin
        data_d = {data_q[23:0], rx_data};
        if (cnt_q == 2'd3) state_d = BUS_WR;
      end
      BUS_WR: begin
        state_d = RESP;
        resp_d  = {8'h4B, 24'h0};
        last_d  = 2'd0;
      end
      BUS_RD: state_d = WAIT_RD;
      WAIT_RD: if (bus_rd_valid) begin
        state_d = RESP;
        resp_d  = bus_rd_data;
        last_d  = 2'd3;
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = RESP;
        resp_d  = {8'hEE, 24'h0};
        last_d  = 2'd0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      RESP: if (tx_fire) begin
        if (cnt_q == last_q) state_d = IDLE;
        resp_d = {resp_q[23:0], 8'h00};
      end
      default: state_d = IDLE;
    endcase
    cnt_d  = (state_d != state_q) ? 2'd0 : cnt_q + {1'b0, rx_fire | tx_fire};
    mask_d = (state_d == BUS_WR || state_d == BUS_RD) ? 4'hF : (state_d == IDLE ? 4'h0 : mask_q);
  end
  always_comb begin
    rx_ready    = state_q == IDLE || state_q == ADDR || state_q == DATA;
    tx_valid    = state_q == RESP;
    rx_fire     = rx_valid && rx_ready;
    tx_fire     = tx_valid && tx_ready;
    tx_data     = tx_valid ? resp_q[31:24] : 8'h00;
    bus_en      = !rst && (state_q == BUS_WR || state_q == BUS_RD);
    bus_rdwr    = state_q == BUS_WR;
    bus_mask    = mask_q;
    bus_addr    = {addr_q[31:2], 2'b00};
    bus_wr_data = data_q;
    busy        = state_q != IDLE;
  end
endmodule

// File: tb/tb_bus_debug_bridge.sv
// tb_bus_debug_bridge: table-driven command vectors plus timeout, backpressure and mid-command reset sequences.
module tb_bus_debug_bridge;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst, rx_valid, rx_ready, tx_valid, tx_ready, bus_en, bus_rdwr, bus_rd_valid, busy;
  logic [7:0] rx_data, tx_data;
  logic [3:0] bus_mask;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  int checks = 0, failures = 0, en_cnt = 0;
  logic [31:0] cap_addr, cap_data;
  logic [3:0] cap_mask;
  logic cap_rdwr, strobe_rd, rsp_on;
  logic [7:0] b;
  always #5 clk = ~clk;
  bus_debug_bridge #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_en(bus_en),
    .bus_rdwr(bus_rdwr), .bus_mask(bus_mask), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rd_valid(bus_rd_valid), .busy(busy)
  );
  always @(negedge clk) begin
    strobe_rd = bus_en && !bus_rdwr && rsp_on;
    if (bus_en) begin
      en_cnt++;
      cap_addr = bus_addr;
      cap_data = bus_wr_data;
      cap_mask = bus_mask;
      cap_rdwr = bus_rdwr;
    end
  end
  // Responder answers one cycle after a read strobe.
  always @(posedge clk) begin
    #1 bus_rd_valid = strobe_rd;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    rx_data = v;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", 32'(n), 32'd0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic recv_byte(output logic [7:0] v);
    int n = 0;
    v = 8'h00;
    @(negedge clk);
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      chk("tx_valid_wait", 32'(n), 32'd0);
      return;
    end
    v = tx_data;
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask
  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd;
    logic [31:0] resp;
    int          nresp;
    int          pulses;
    logic        rdwr;
    logic [31:0] baddr;
  } vec_t;
  vec_t vt[6];
  initial begin
    int base, n;
    vt[0] = '{8'h57, 32'h80000004, 32'hDEADBEEF, 32'h0, 32'h4B000000, 1, 1, 1'b1, 32'h80000004};
    vt[1] = '{8'h52, 32'h00000103, 32'h0, 32'h12345678, 32'h12345678, 4, 1, 1'b0, 32'h00000100};
    vt[2] = '{8'h41, 32'h0, 32'h0, 32'h0, 32'h3F000000, 1, 0, 1'b0, 32'h0};
    vt[3] = '{8'h57, 32'h00000007, 32'h01020304, 32'h0, 32'h4B000000, 1, 1, 1'b1, 32'h00000004};
    vt[4] = '{8'h52, 32'hFFFFFFFF, 32'h0, 32'hA5A55A5A, 32'hA5A55A5A, 4, 1, 1'b0, 32'hFFFFFFFC};
    vt[5] = '{8'h00, 32'h0, 32'h0, 32'h0, 32'h3F000000, 1, 0, 1'b0, 32'h0};
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    bus_rd_data = 32'h0; rsp_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_bus_en", 32'(bus_en), 32'd0);
    chk("rst_bus_rdwr", 32'(bus_rdwr), 32'd0);
    chk("rst_bus_mask", 32'(bus_mask), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wr_data", bus_wr_data, 32'd0);
    for (int v = 0; v < 6; v++) begin
      base = en_cnt;
      bus_rd_data = vt[v].rd;
      send_byte(vt[v].op);
      if (vt[v].op == 8'h57 || vt[v].op == 8'h52) send_word(vt[v].addr);
      if (vt[v].op == 8'h57) send_word(vt[v].data);
      for (int i = 0; i < vt[v].nresp; i++) begin
        recv_byte(b);
        chk($sformatf("v%0d_resp%0d", v, i), 32'(b), 32'(vt[v].resp[31-8*i -: 8]));
      end
      @(negedge clk);
      chk($sformatf("v%0d_pulses", v), 32'(en_cnt - base), 32'(vt[v].pulses));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      if (vt[v].pulses == 1) begin
        chk($sformatf("v%0d_addr", v), cap_addr, vt[v].baddr);
        chk($sformatf("v%0d_rdwr", v), 32'(cap_rdwr), 32'(vt[v].rdwr));
        if (vt[v].rdwr) begin
          chk($sformatf("v%0d_wdata", v), cap_data, vt[v].data);
          chk($sformatf("v%0d_mask", v), 32'(cap_mask), 32'hF);
        end
      end
    end
    // Read timeout: no responder, 0xEE appears T cycles after WAIT_RD entry.
    rsp_on = 1'b0;
    base = en_cnt;
    send_byte(8'h52);
    send_word(32'h00000010);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 1000);
    chk("tmo_latency", 32'(n), 32'(T + 2));
    recv_byte(b);
    chk("tmo_byte", 32'(b), 32'hEE);
    @(negedge clk);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_pulses", 32'(en_cnt - base), 32'd1);
    chk("tmo_rdwr", 32'(cap_rdwr), 32'd0);
    // Backpressure on a read response.
    rsp_on = 1'b1;
    bus_rd_data = 32'h12345678;
    send_byte(8'h52);
    send_word(32'h00000000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 100);
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_valid", 32'(tx_valid), 32'd1);
      chk("bp_tx_data", 32'(tx_data), 32'h12);
      @(negedge clk);
    end
    chk("bp_mask_hold", 32'(bus_mask), 32'hF);
    chk("bp_addr_hold", bus_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      chk($sformatf("bp_resp%0d", i), 32'(b), 32'(8'h12 + 8'(i * 8'h22)));
    end
    @(negedge clk);
    chk("bp_tx_valid_end", 32'(tx_valid), 32'd0);
    chk("bp_busy_end", 32'(busy), 32'd0);
    // Reset in the middle of a write command.
    send_byte(8'h57);
    send_byte(8'h80);
    send_byte(8'h00);
    @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rx_ready", 32'(rx_ready), 32'd1);
    chk("mid_addr", bus_addr, 32'd0);
    bus_rd_data = 32'hCAFEF00D;
    base = en_cnt;
    send_byte(8'h52);
    send_word(32'h00000000);
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      chk($sformatf("mid_resp%0d", i), 32'(b), 32'(bus_rd_data[31-8*i -: 8]));
    end
    chk("mid_pulses", 32'(en_cnt - base), 32'd1);
    chk("mid_rd_addr", cap_addr, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_debug_bridge.md
BUS_DEBUG_BRIDGE -- requirements
Module: bus_debug_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, meaning the maximum cycles WAIT_RD waits for bus_rd_valid.
REQ-002 SHALL have one clock and synchronous active-high reset: clk  input  1  clock, all state updates on posedge.
REQ-003 SHALL have rst  input  1  synchronous active-high reset.
REQ-004 SHALL have rx_data  input  8  command byte from UART receiver.
REQ-005 SHALL have rx_valid  input  1  rx_data valid; rx_ready  output  1  bridge accepts the byte; transfer occurs when both are high.
REQ-006 SHALL have tx_data  output  8  response byte to UART transmitter.
REQ-007 SHALL have tx_valid  output  1  and tx_ready  input  1; transfer occurs when both are high.
REQ-008 SHALL have bus_en  output  1  system bus request strobe.
REQ-009 SHALL have bus_rdwr  output  1  bus direction: 1 = write, 0 = read.
REQ-010 SHALL have bus_mask  output  4  byte-lane mask, and bus_addr  output  32  word address.
REQ-011 SHALL have bus_wr_data  output  32  write data, and bus_rd_data  input  32  read data.
REQ-012 SHALL have bus_rd_valid  input  1  read data valid.
REQ-013 SHALL have busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, ADDR, DATA, BUS_WR, BUS_RD, WAIT_RD and RESP.
REQ-015 IDLE on an accepted byte: 0x57 ('W') -> ADDR (write); 0x52 ('R') -> ADDR (read); any other byte -> RESP with the single byte 0x3F.
REQ-016 ADDR SHALL accept 4 bytes, MSB first, into the address register, then go to DATA for a write or BUS_RD for a read.
REQ-017 DATA SHALL accept 4 bytes, MSB first, into the data register, then go to BUS_WR.
REQ-018 rx_ready SHALL be 1 only in IDLE, ADDR and DATA, and 0 in all other states.
REQ-019 bus_addr SHALL be {addr_reg[31:2], 2'b00}, so addr_reg[1:0] is ignored.
REQ-020 BUS_WR SHALL drive, for exactly 1 cycle, bus_en=1, bus_rdwr=1, bus_mask=4'hF and bus_wr_data=data_reg, then go to RESP with the single byte 0x4B ('K').
REQ-021 BUS_RD SHALL drive bus_en=1, bus_rdwr=0 for exactly 1 cycle, then go to WAIT_RD and clear the timeout counter.
REQ-022 WAIT_RD on bus_rd_valid=1 SHALL capture bus_rd_data and go to RESP with 4 bytes, MSB first; the nominal latency is 1 cycle after the BUS_RD strobe.
REQ-023 WAIT_RD SHALL go to RESP with the single byte 0xEE if bus_rd_valid has not been seen after TIMEOUT_CYC cycles.
REQ-024 bus_rd_valid outside WAIT_RD SHALL be ignored.
REQ-025 bus_en SHALL be 0 outside BUS_WR and BUS_RD.
REQ-026 bus_addr, bus_wr_data and bus_mask SHALL be held stable from the strobe until the state returns to IDLE.
REQ-027 RESP SHALL hold tx_valid=1 with a stable tx_data until tx_ready=1, then advance the response byte counter.
REQ-028 RESP SHALL return to IDLE after the final response byte is accepted.
REQ-029 tx_valid SHALL be 0 outside RESP.
REQ-030 The 2-bit byte counters SHALL reset to 0 on every state entry.
REQ-031 The bridge SHALL handle one command at a time; bytes offered while rx_ready=0 SHALL not be consumed.
REQ-032 When rx_valid and tx_ready are both high in the same cycle, only the signal relevant to the current state SHALL take effect.
REQ-033 There SHALL be no command abort other than rst; an incomplete command stalls in ADDR or DATA indefinitely.
REQ-034 The timeout counter SHALL be wide enough to count to TIMEOUT_CYC without wrapping.

Reset
REQ-035 rst SHALL force state=IDLE, clear all counters, address and data registers, and drive bus_en=0, bus_rdwr=0, bus_mask=0, bus_addr=0, bus_wr_data=0, tx_valid=0, tx_data=0 and busy=0.
REQ-036 rx_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-037 rst asserted in any state, including mid-command or mid-response, SHALL discard all partial state.
REQ-038 A bus strobe SHALL not be issued in the cycle rst is high.

Verification
REQ-039 Write: bytes 57 80 00 00 04 DE AD BE EF -> one cycle with bus_en=1, rdwr=1, addr=0x80000004, wr_data=0xDEADBEEF, mask=F, then tx byte 0x4B.
REQ-040 Read: bytes 52 00 00 01 03 with a responder returning 0x12345678 one cycle later -> bus_addr=0x00000100, rdwr=0, then tx bytes 12 34 56 78.
REQ-041 Bad command: byte 0x41 -> tx byte 0x3F, no bus_en pulse, return to IDLE.
REQ-042 Timeout: read with bus_rd_valid held 0 -> tx byte 0xEE exactly TIMEOUT_CYC cycles after WAIT_RD entry.
REQ-043 Backpressure: during a read response, hold tx_ready=0 for 10 cycles -> tx_data stays 0x12, tx_valid stays 1, no bytes are lost or duplicated.
REQ-044 Reset mid-command: after 57 80 00, pulse rst -> busy=0; the next sequence 52 00 00 00 00 completes as a normal read.
